div_issue_ctrl: RTL and testbench

- Sits between the execute-stage issue logic and the radix-2 SRT divider wrapper.
- Accepts one divide/modulo request at a time over a valid/ready handshake and registers its operands.
- Resolves special cases locally: divide by zero, and signed INT_MIN / -1.
- All other requests drive the divider's request/hold interface until div_ok; the result is presented to writeback on a valid/ready handshake, and a pipeline flush aborts the operation in flight.

---
 rtl/div_issue_ctrl_if.sv | 56 +++++
 rtl/div_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl_if
// Purpose : bundles every handshake and bus signal of div_issue_ctrl so the
//           issue stage, the SRT divider wrapper and writeback connect
//           through one port.
// Signals :
//   issue side     in_valid/in_ready, in_signed, in_mod, in_x, in_y, in_tag,
//                  flush
//   divider side   div_req, div_signed_o, div_mod_o, div_x, div_y, div_abort,
//                  div_result, div_ok
//   writeback side out_valid/out_ready, out_data, out_tag, out_err
// Modports:
//   slave  - the controller itself
//   master - everything around it (issue stage, divider, writeback, bench)
// ---------------------------------------------------------------------------
interface div_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic             in_mod;
    logic [31:0]      in_x;
    logic [31:0]      in_y;
    logic [TAG_W-1:0] in_tag;
    logic             flush;

    logic             div_req;
    logic             div_signed_o;
    logic             div_mod_o;
    logic [31:0]      div_x;
    logic [31:0]      div_y;
    logic             div_abort;
    logic [31:0]      div_result;
    logic             div_ok;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport slave (
        input  in_valid, in_signed, in_mod, in_x, in_y, in_tag, flush,
        input  div_result, div_ok, out_ready,
        output in_ready, div_req, div_signed_o, div_mod_o, div_x, div_y,
        output div_abort, out_valid, out_data, out_tag, out_err
    );

    modport master (
        output in_valid, in_signed, in_mod, in_x, in_y, in_tag, flush,
        output div_result, div_ok, out_ready,
        input  in_ready, div_req, div_signed_o, div_mod_o, div_x, div_y,
        input  div_abort, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
// Purpose : issue controller in front of the radix-2 SRT divider. Accepts
//           one divide/modulo request at a time, resolves divide-by-zero and
//           signed INT_MIN / -1 locally, otherwise holds the divider request
//           until div_ok (or a watchdog timeout), then presents the result to
//           writeback. A flush kills whatever is accepted or in flight.
// Ports   :
//   clk     - clock
//   resetn  - asynchronous active-low reset
//   bus     - div_issue_ctrl_if.slave (issue, divider and writeback signals)
// Parameters:
//   TAG_W   - destination tag width
//   TIMEOUT - divider cycles allowed before abort with out_err
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 48
) (
    input  logic           clk,
    input  logic           resetn,
    div_issue_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [31:0]        opX_q,    opX_d;
    logic [31:0]        opY_q,    opY_d;
    logic               opSigned_q, opSigned_d;
    logic               opMod_q,  opMod_d;
    logic [TAG_W-1:0]   tag_q,    tag_d;
    logic [31:0]        data_q,   data_d;
    logic               err_q,    err_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               abort_q,  abort_d;

    logic               inReady;
    logic               accept;
    logic [CNT_W-1:0]   cntNext;

    // Ready is combinational so a retiring result and a new request can share
    // a cycle; flush always blocks acceptance.
    always_comb begin
        inReady = 1'b0;
        case (state_q)
            IDLE:    inReady = ~bus.flush;
            DONE:    inReady = bus.out_ready & ~bus.flush;
            default: inReady = 1'b0;
        endcase
    end

    assign accept  = bus.in_valid & inReady;
    assign cntNext = cnt_q + 1'b1;

    // Next-state logic. A new request is loaded after the per-state case so
    // the IDLE and DONE acceptance paths share one load block.
    always_comb begin
        state_d    = state_q;
        opX_d      = opX_q;
        opY_d      = opY_q;
        opSigned_d = opSigned_q;
        opMod_d    = opMod_q;
        tag_d      = tag_q;
        data_d     = data_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        abort_d    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            BUSY: begin
                // div_ok only counts here: the divider reports ok while idle.
                if (bus.flush) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (bus.div_ok) begin
                    data_d  = bus.div_result;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cntNext == CNT_W'(TIMEOUT)) begin
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                    data_d  = 32'h0;
                    state_d = DONE;
                end else begin
                    cnt_d = cntNext;
                end
            end
            DONE: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            opX_d      = bus.in_x;
            opY_d      = bus.in_y;
            opSigned_d = bus.in_signed;
            opMod_d    = bus.in_mod;
            tag_d      = bus.in_tag;
            cnt_d      = '0;
            err_d      = 1'b0;
            if (bus.in_y == 32'h0) begin
                data_d  = bus.in_mod ? bus.in_x : 32'hFFFF_FFFF;
                state_d = DONE;
            end else if (bus.in_signed && bus.in_x == 32'h8000_0000 &&
                         bus.in_y == 32'hFFFF_FFFF) begin
                data_d  = bus.in_mod ? 32'h0 : 32'h8000_0000;
                state_d = DONE;
            end else begin
                state_d = BUSY;
            end
        end
    end

    // State and datapath registers. div_req decodes from state_q, so reset
    // drops it asynchronously; going through DONE guarantees at least one
    // low cycle between consecutive divider operations.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            opX_q      <= '0;
            opY_q      <= '0;
            opSigned_q <= 1'b0;
            opMod_q    <= 1'b0;
            tag_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            opX_q      <= opX_d;
            opY_q      <= opY_d;
            opSigned_q <= opSigned_d;
            opMod_q    <= opMod_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.in_ready     = inReady;
    assign bus.div_req      = (state_q == BUSY);
    assign bus.div_signed_o = opSigned_q;
    assign bus.div_mod_o    = opMod_q;
    assign bus.div_x        = opX_q;
    assign bus.div_y        = opY_q;
    assign bus.div_abort    = abort_q;
    assign bus.out_valid    = (state_q == DONE);
    assign bus.out_data     = data_q;
    assign bus.out_tag      = tag_q;
    assign bus.out_err      = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
// Purpose : self-checking bench for div_issue_ctrl. A behavioural divider
//           stub answers div_req after a programmable latency (or never),
//           and a scoreboard queue holds the expected writeback results.
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;

    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 48;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    int   checks      = 0;
    int   failures    = 0;
    int   stubLat     = 4;
    bit   stubKill    = 1'b0;
    int   abortCycles = 0;
    exp_t sbQ[$];

    div_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] refDiv(input logic sgn, input logic md,
                                           input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return md ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md ? 32'h0 : 32'h8000_0000;
            return md ? (sa % sb) : (sa / sb);
        end
        return md ? (a % b) : (a / b);
    endfunction

    // Divider stub: reports ok while idle, drops ok when a request starts and
    // raises it with the result after stubLat cycles unless stubKill is set.
    initial begin
        int stubCnt;
        stubCnt        = 0;
        bus.div_ok     = 1'b1;
        bus.div_result = 32'h0;
        forever begin
            @(negedge clk);
            if (!bus.div_req) begin
                stubCnt        = 0;
                bus.div_ok     = 1'b1;
                bus.div_result = 32'h0;
            end else begin
                stubCnt++;
                if (!stubKill && stubCnt > stubLat) begin
                    bus.div_ok     = 1'b1;
                    bus.div_result = refDiv(bus.div_signed_o, bus.div_mod_o, bus.div_x, bus.div_y);
                end else begin
                    bus.div_ok = 1'b0;
                end
            end
        end
    end

    // Abort pulse counter and divider operand stability monitor.
    initial begin
        logic        prevReq;
        logic [31:0] prevX;
        logic [31:0] prevY;
        prevReq = 1'b0;
        prevX   = 32'h0;
        prevY   = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.div_abort === 1'b1) abortCycles++;
            if (bus.div_req === 1'b1 && prevReq) begin
                checks++;
                if (bus.div_x !== prevX || bus.div_y !== prevY) begin
                    failures++;
                    $display("[TB] FAIL div_operands_stable: got x=%h y=%h expected x=%h y=%h",
                             bus.div_x, bus.div_y, prevX, prevY);
                end
            end
            prevReq = (bus.div_req === 1'b1);
            prevX   = bus.div_x;
            prevY   = bus.div_y;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic sendReq(input logic sgn, input logic md, input logic [31:0] x,
                           input logic [31:0] y, input logic [TAG_W-1:0] tag,
                           input bit pushExp, input logic [31:0] expData,
                           input logic expErr, input string name);
        int   waited;
        exp_t e;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_signed = sgn;
        bus.in_mod    = md;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_tag    = tag;
        #1;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_accept: got in_ready=%b expected 1", name, bus.in_ready);
        end else begin
            @(posedge clk);
            if (pushExp) begin
                e.data = expData;
                e.tag  = tag;
                e.err  = expErr;
                sbQ.push_back(e);
            end
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collectResp(input string name, output int waitCycles, output int reqCycles);
        exp_t e;
        waitCycles = 0;
        reqCycles  = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && waitCycles < TIMEOUT + 20) begin
            if (bus.div_req === 1'b1) reqCycles++;
            waitCycles++;
            @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_out_valid: got %b expected 1", name, bus.out_valid);
        end
        checks++;
        if (sbQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s_scoreboard: got empty queue expected an entry", name);
        end else begin
            e = sbQ.pop_front();
            if (bus.out_data !== e.data) begin
                failures++;
                $display("[TB] FAIL %s_data: got %h expected %h", name, bus.out_data, e.data);
            end
            checks++;
            if (bus.out_tag !== e.tag) begin
                failures++;
                $display("[TB] FAIL %s_tag: got %0d expected %0d", name, bus.out_tag, e.tag);
            end
            checks++;
            if (bus.out_err !== e.err) begin
                failures++;
                $display("[TB] FAIL %s_err: got %b expected %b", name, bus.out_err, e.err);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_mod    = 1'b0;
        bus.in_x      = 32'h0;
        bus.in_y      = 32'h0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        resetn        = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.div_req !== 1'b0 ||
            bus.div_abort !== 1'b0 || bus.out_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got rdy=%b ov=%b req=%b abt=%b err=%b expected 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.div_req, bus.div_abort, bus.out_err);
        end
        checks++;
        if (bus.out_data !== 32'h0 || bus.out_tag !== '0 || bus.div_x !== 32'h0 || bus.div_y !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_data: got data=%h tag=%0d x=%h y=%h expected zeros",
                     bus.out_data, bus.out_tag, bus.div_x, bus.div_y);
        end
        resetn = 1'b1;
    endtask

    task automatic test_unsigned();
        int w, r;
        stubLat = 4;
        sendReq(1'b0, 1'b0, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14, 1'b0, "udiv");
        collectResp("udiv", w, r);
        checks++;
        if (w != 5 || r != 5) begin
            failures++;
            $display("[TB] FAIL udiv_latency: got wait=%0d req=%0d expected 5 5", w, r);
        end
        sendReq(1'b0, 1'b1, 32'd100, 32'd7, 5'd4, 1'b1, 32'd2, 1'b0, "umod");
        collectResp("umod", w, r);
        // Not a special case when unsigned: goes through the divider.
        sendReq(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h0, 1'b0, "ubig");
        collectResp("ubig", w, r);
        checks++;
        if (r != 5) begin
            failures++;
            $display("[TB] FAIL ubig_div_used: got req=%0d expected 5", r);
        end
    endtask

    task automatic test_signed();
        int w, r;
        sendReq(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, 32'hFFFF_FFFD, 1'b0, "sdiv");
        collectResp("sdiv", w, r);
        sendReq(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 32'hFFFF_FFFF, 1'b0, "smod");
        collectResp("smod", w, r);
    endtask

    task automatic test_special_cases();
        int w, r;
        sendReq(1'b0, 1'b0, 32'd5, 32'd0, 5'd7, 1'b1, 32'hFFFF_FFFF, 1'b0, "dz_div");
        collectResp("dz_div", w, r);
        checks++;
        if (w != 0 || r != 0) begin
            failures++;
            $display("[TB] FAIL dz_latency: got wait=%0d req=%0d expected 0 0", w, r);
        end
        sendReq(1'b1, 1'b1, 32'd5, 32'd0, 5'd8, 1'b1, 32'd5, 1'b0, "dz_mod");
        collectResp("dz_mod", w, r);
        sendReq(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, 32'h8000_0000, 1'b0, "ovf_div");
        collectResp("ovf_div", w, r);
        checks++;
        if (w != 0 || r != 0) begin
            failures++;
            $display("[TB] FAIL ovf_latency: got wait=%0d req=%0d expected 0 0", w, r);
        end
        sendReq(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h0, 1'b0, "ovf_mod");
        collectResp("ovf_mod", w, r);
    endtask

    task automatic test_flush();
        int  w, r, a0;
        bit  sawValid;
        stubLat = 20;
        a0 = abortCycles;
        sendReq(1'b0, 1'b0, 32'd50, 32'd5, 5'd11, 1'b0, 32'h0, 1'b0, "flush_busy");
        repeat (2) @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.div_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_pre_req: got %b expected 1", bus.div_req);
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.div_req !== 1'b0 || bus.div_abort !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_busy: got req=%b abt=%b ov=%b expected 0 1 0",
                     bus.div_req, bus.div_abort, bus.out_valid);
        end
        sawValid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) sawValid = 1'b1;
        end
        checks++;
        if (sawValid || abortCycles - a0 != 1) begin
            failures++;
            $display("[TB] FAIL flush_aftermath: got valid_seen=%b abort_cycles=%0d expected 0 1",
                     sawValid, abortCycles - a0);
        end
        stubLat = 4;
        sendReq(1'b0, 1'b0, 32'd9, 32'd3, 5'd12, 1'b1, 32'd3, 1'b0, "post_flush");
        collectResp("post_flush", w, r);

        // Flush while idle blocks acceptance.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = 32'd9;
        bus.in_y     = 32'd0;
        bus.flush    = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_idle_ready: got %b expected 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.div_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_idle_accept: got ov=%b req=%b expected 0 0",
                     bus.out_valid, bus.div_req);
        end

        // Flush while a result waits drops it.
        sendReq(1'b0, 1'b0, 32'd9, 32'd0, 5'd13, 1'b0, 32'h0, 1'b0, "flush_done");
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_done_pre: got %b expected 1", bus.out_valid);
        end
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_done: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int          w, r, waited;
        bit          bad;
        logic [31:0] held;
        exp_t        e;
        stubLat = 3;
        sendReq(1'b0, 1'b0, 32'd1000, 32'd10, 5'd14, 1'b1, 32'd100, 1'b0, "bp");
        waited = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        // Next request waits on in_valid while writeback stalls.
        bus.in_valid  = 1'b1;
        bus.in_signed = 1'b0;
        bus.in_mod    = 1'b0;
        bus.in_x      = 32'd6;
        bus.in_y      = 32'd2;
        bus.in_tag    = 5'd16;
        e.data = 32'd3;
        e.tag  = 5'd16;
        e.err  = 1'b0;
        held = bus.out_data;
        bad  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0 ||
                bus.div_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || held !== 32'd100) begin
            failures++;
            $display("[TB] FAIL backpressure: got bad=%b data=%h expected 0 %h", bad, held, 32'd100);
        end
        sbQ.push_back(e);
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ready: got %b expected 1", bus.in_ready);
        end
        bus.out_ready = 1'b0;
        collectResp("bp", w, r);
        bus.in_valid = 1'b0;
        collectResp("b2b", w, r);
        checks++;
        if (w != 4 || r != 4) begin
            failures++;
            $display("[TB] FAIL b2b_latency: got wait=%0d req=%0d expected 4 4", w, r);
        end
    endtask

    task automatic test_watchdog();
        int w, r, a0;
        stubKill = 1'b1;
        a0 = abortCycles;
        sendReq(1'b0, 1'b0, 32'd77, 32'd7, 5'd17, 1'b1, 32'h0, 1'b1, "wdog");
        collectResp("wdog", w, r);
        stubKill = 1'b0;
        checks++;
        if (w != TIMEOUT || r != TIMEOUT || abortCycles - a0 != 1) begin
            failures++;
            $display("[TB] FAIL wdog_timing: got wait=%0d req=%0d aborts=%0d expected %0d %0d 1",
                     w, r, abortCycles - a0, TIMEOUT, TIMEOUT);
        end
        stubLat = 4;
        sendReq(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd10, 5'd18, 1'b1, 32'hFFFF_FFF6, 1'b0, "post_wdog");
        collectResp("post_wdog", w, r);
    endtask

    task automatic test_reset_mid();
        int w, r;
        stubLat = 20;
        sendReq(1'b0, 1'b0, 32'd10, 32'd2, 5'd19, 1'b0, 32'h0, 1'b0, "rst_mid");
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.div_req !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid: got req=%b rdy=%b data=%h expected 0 1 0",
                     bus.div_req, bus.in_ready, bus.out_data);
        end
        @(negedge clk);
        resetn  = 1'b1;
        stubLat = 4;
        sendReq(1'b0, 1'b1, 32'd23, 32'd5, 5'd20, 1'b1, 32'd3, 1'b0, "post_reset");
        collectResp("post_reset", w, r);
    endtask

    initial begin
        $display("[TB] starting div_issue_ctrl bench");
        test_reset();
        test_unsigned();
        test_signed();
        test_special_cases();
        test_flush();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
